// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl: bit-serial XOR/XNOR/ADD/SUB sequencer around one alu1bit.
// Processes WIDTH bits LSB first, one bit per clock, with the inter-bit
// carry held in a flop. Optional feature macro: ALU_SERIAL_OVF_EN adds a
// signed-overflow output (ovf) for ADD/SUB.

module alu1bit #(
  parameter int nand_tpd = 1,
  parameter int or_tpd   = 1,
  parameter int xnor_tpd = 1
) (
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [1:0] op,
  output logic       s,
  output logic       cout
);
  // Gate delays only describe the cin->s/cout path for clock planning;
  // they must be non-negative to be meaningful.
  if (nand_tpd < 0 || or_tpd < 0 || xnor_tpd < 0) begin : g_tpd_chk
    $error("alu1bit: negative gate delay parameter");
  end

  logic bb;
  assign bb = b ^ op[0];  // op[0] inverts b: XNOR for logic ops, ~b for SUB

  // Logic ops ignore cin; arithmetic ops form a full adder.
  always_comb begin
    s    = a ^ bb;
    cout = 1'b0;
    if (op[1]) begin
      s    = a ^ bb ^ cin;
      cout = (a & bb) | (a & cin) | (bb & cin);
    end
  end
endmodule

module alu_serial_ctrl #(
  parameter int WIDTH    = 8,
  parameter int nand_tpd = 1,
  parameter int or_tpd   = 1,
  parameter int xnor_tpd = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
`ifdef ALU_SERIAL_OVF_EN
  , output logic           ovf
`endif
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  if (WIDTH < 2) begin : g_width_chk
    $error("alu_serial_ctrl: WIDTH must be >= 2");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] r_sh_q, r_sh_d;
  logic [1:0]       op_q, op_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             done_q, done_d;
`ifdef ALU_SERIAL_OVF_EN
  logic             cmsb_q, cmsb_d;  // carry into the MSB position
  logic             ovf_q, ovf_d;
`endif

  logic alu_s, alu_cout;

  alu1bit #(
    .nand_tpd (nand_tpd),
    .or_tpd   (or_tpd),
    .xnor_tpd (xnor_tpd)
  ) u_alu (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .op   (op_q),
    .s    (alu_s),
    .cout (alu_cout)
  );

  // Next-state and datapath updates; every _d defaults to hold.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    r_sh_d   = r_sh_q;
    op_d     = op_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    cout_d   = cout_q;
    done_d   = 1'b0;
`ifdef ALU_SERIAL_OVF_EN
    cmsb_d   = cmsb_q;
    ovf_d    = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a_in;
          b_sh_d  = b_in;
          op_d    = op;
          cnt_d   = '0;
          carry_d = op[0];  // +1 seed turns a + ~b into a - b
          state_d = RUN;
        end
      end
      RUN: begin
        r_sh_d  = {alu_s, r_sh_q[WIDTH-1:1]};
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        carry_d = alu_cout;
        if (cnt_q == LAST) begin
`ifdef ALU_SERIAL_OVF_EN
          cmsb_d = carry_q;
`endif
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        result_d = r_sh_q;
        cout_d   = op_q[1] ? carry_q : 1'b0;
`ifdef ALU_SERIAL_OVF_EN
        ovf_d    = op_q[1] ? (cmsb_q ^ carry_q) : 1'b0;
`endif
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      r_sh_q   <= '0;
      op_q     <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef ALU_SERIAL_OVF_EN
      cmsb_q   <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      r_sh_q   <= r_sh_d;
      op_q     <= op_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      done_q   <= done_d;
`ifdef ALU_SERIAL_OVF_EN
      cmsb_q   <= cmsb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;
`ifdef ALU_SERIAL_OVF_EN
  assign ovf    = ovf_q;
`endif
endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Bench for alu_serial_ctrl (WIDTH=8): directed cases with literal results,
// plus randomized traffic checked each cycle against a behavioural model.
module tb_alu_serial_ctrl;
  localparam int W = 8;
  localparam logic [1:0] XOR = 2'b00, XNOR = 2'b01, ADD = 2'b10, SUB = 2'b11;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = '0;
  logic [W-1:0] a_in = '0, b_in = '0;
  logic         busy, done, cout;
  logic [W-1:0] result;
`ifdef ALU_SERIAL_OVF_EN
  logic         ovf;
`endif

  alu_serial_ctrl #(.WIDTH(W), .nand_tpd(1), .or_tpd(1), .xnor_tpd(1)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a_in   (a_in),
    .b_in   (b_in),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout)
`ifdef ALU_SERIAL_OVF_EN
    , .ovf  (ovf)
`endif
  );

  always #10 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: returns {ovf, cout, result} from plain arithmetic.
  function automatic logic [W+1:0] ref_op(input logic [1:0] o, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic [W:0]   s;
    logic [W-1:0] bb;
    logic         v;
    case (o)
      XOR:     return {2'b00, a ^ b};
      XNOR:    return {2'b00, ~(a ^ b)};
      default: begin
        bb = (o == SUB) ? ~b : b;
        s  = {1'b0, a} + {1'b0, bb} + ((o == SUB) ? (W+1)'(1) : (W+1)'(0));
        v  = (a[W-1] == bb[W-1]) && (s[W-1] != a[W-1]);
        return {v, s};
      end
    endcase
  endfunction

  // Behavioural model: an accepted op keeps the block busy for W+1 edges,
  // then the result appears together with a one-cycle done.
  int           rem = 0;
  logic [W+1:0] pend = '0;
  logic         e_busy = 1'b0, e_done = 1'b0, e_cout = 1'b0, e_ovf = 1'b0;
  logic [W-1:0] e_res = '0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      rem = 0; e_busy = 0; e_done = 0; e_res = '0; e_cout = 0; e_ovf = 0;
    end else if (rem > 0) begin
      rem--;
      e_done = 1'b0;
      if (rem == 0) begin
        e_done = 1'b1;
        {e_ovf, e_cout, e_res} = pend;
      end
      e_busy = (rem > 0);
    end else begin
      e_done = 1'b0;
      if (start) begin
        pend = ref_op(op, a_in, b_in);
        rem  = W + 1;
      end
      e_busy = (rem > 0);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("busy",   32'(busy),   32'(e_busy));
      check("done",   32'(done),   32'(e_done));
      check("result", 32'(result), 32'(e_res));
      check("cout",   32'(cout),   32'(e_cout));
`ifdef ALU_SERIAL_OVF_EN
      check("ovf",    32'(ovf),    32'(e_ovf));
`endif
    end
  end

  // One op: issue, scramble inputs while busy, wait (bounded) for done.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] xr, input logic xc, input string nm);
    int k;
    @(negedge clk); #1;
    start = 1'b1; op = o; a_in = a; b_in = b;
    @(negedge clk);
    k = 0;
    #1;
    start = 1'b0; op = 2'($urandom); a_in = W'($urandom); b_in = W'($urandom);
    while (done !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check({nm, "_latency"}, 32'(k), 32'(W + 1));
    check({nm, "_result"}, 32'(result), 32'(xr));
    check({nm, "_cout"}, 32'(cout), 32'(xc));
  endtask

  int ndone;

  initial begin
    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_result", 32'(result), 32'(0));
    check("rst_cout", 32'(cout), 32'(0));
`ifdef ALU_SERIAL_OVF_EN
    check("rst_ovf", 32'(ovf), 32'(0));
`endif
    #1 rst = 1'b0;
    chk_en = 1'b1;

    // Pin the reference model with hand-computed values.
    check("ref_add_3c_05", 32'(ref_op(ADD, 8'h3c, 8'h05)), 32'(10'h041));
    check("ref_sub_05_06", 32'(ref_op(SUB, 8'h05, 8'h06)), 32'(10'h0ff));
    check("ref_add_7f_01", 32'(ref_op(ADD, 8'h7f, 8'h01)), 32'(10'h280));
    check("ref_sub_80_01", 32'(ref_op(SUB, 8'h80, 8'h01)), 32'(10'h37f));
    check("ref_xnor",      32'(ref_op(XNOR, 8'ha5, 8'h0f)), 32'(10'h055));

    // Directed operations.
    run_op(ADD,  8'h3c, 8'h05, 8'h41, 1'b0, "add_3c_05");
    run_op(ADD,  8'hff, 8'h01, 8'h00, 1'b1, "add_ff_01");
    run_op(SUB,  8'h05, 8'h06, 8'hff, 1'b0, "sub_05_06");
    run_op(SUB,  8'h06, 8'h05, 8'h01, 1'b1, "sub_06_05");
    run_op(XOR,  8'ha5, 8'h0f, 8'haa, 1'b0, "xor");
    run_op(XNOR, 8'ha5, 8'h0f, 8'h55, 1'b0, "xnor");
    run_op(ADD,  8'h7f, 8'h01, 8'h80, 1'b0, "add_7f_01");
`ifdef ALU_SERIAL_OVF_EN
    check("ovf_7f_01", 32'(ovf), 32'(1));
`endif
    run_op(SUB,  8'h80, 8'h01, 8'h7f, 1'b1, "sub_80_01");
`ifdef ALU_SERIAL_OVF_EN
    check("ovf_80_01", 32'(ovf), 32'(1));
`endif
    run_op(ADD,  8'h10, 8'h20, 8'h30, 1'b0, "add_10_20");
`ifdef ALU_SERIAL_OVF_EN
    check("ovf_10_20", 32'(ovf), 32'(0));
`endif

    // Start while busy must be ignored.
    @(negedge clk); #1;
    start = 1'b1; op = ADD; a_in = 8'h01; b_in = 8'h01;
    @(negedge clk); #1 start = 1'b0;
    repeat (3) @(negedge clk);
    #1 start = 1'b1; op = SUB; a_in = 8'hff; b_in = 8'h00;
    @(negedge clk); #1 start = 1'b0;
    ndone = 0;
    repeat (25) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    check("busy_prot_ndone", 32'(ndone), 32'(1));
    check("busy_prot_result", 32'(result), 32'(8'h02));

    // Reset in the middle of an op.
    @(negedge clk); #1;
    start = 1'b1; op = ADD; a_in = 8'hff; b_in = 8'hff;
    @(negedge clk); #1 start = 1'b0;
    repeat (4) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_result", 32'(result), 32'(0));
    check("midrst_done", 32'(done), 32'(0));
    @(negedge clk); #1 rst = 1'b0;
    ndone = 0;
    repeat (15) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    check("midrst_no_done", 32'(ndone), 32'(0));
    run_op(ADD, 8'h01, 8'h02, 8'h03, 1'b0, "after_rst");

    // start held high: back-to-back ops with inputs changing every cycle.
    repeat (45) begin
      @(negedge clk); #1;
      start = 1'b1; op = 2'($urandom); a_in = W'($urandom); b_in = W'($urandom);
    end

    // Random traffic with occasional resets.
    repeat (600) begin
      @(negedge clk); #1;
      rst   = ($urandom_range(0, 149) == 0);
      start = ($urandom_range(0, 3) == 0);
      op    = 2'($urandom);
      a_in  = W'($urandom);
      b_in  = W'($urandom);
    end
    @(negedge clk); #1 rst = 1'b0; start = 1'b0;
    repeat (12) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
